// File: rtl/div_iter_param_pkg.sv
// Shared types and constants for the iterative divider.
// Fixup-lane indices select one of the four conditional-negate instances.
package div_iter_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_TAG_W = 5;

  localparam int FIX_ABS_X = 0;
  localparam int FIX_ABS_Y = 1;
  localparam int FIX_Q     = 2;
  localparam int FIX_R     = 3;
  localparam int FIX_N     = 4;

endpackage

// File: rtl/div_iter_param_if.sv
// Request/response handshake between the issue stage and the divider.
// The master side issues operands and collects the result.
interface div_iter_param_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_signed, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_tag
  );

  modport slave (
    input  in_valid, in_signed, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_q, out_r, out_tag
  );
endinterface

// File: rtl/div_sign_fix.sv
// Combinational conditional two's-complement negate, WIDTH-bit wrap.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  assign y = neg ? (~a + ONE) : a;
endmodule

// File: rtl/div_iter_param.sv
// Multi-cycle radix-2 restoring divider with tag passthrough, flush cancel,
// defined divide-by-zero result and optional early-out when |x| < |y|.
module div_iter_param
  import div_iter_param_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH,
  parameter int TAG_W     = DIV_TAG_W,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  output logic            busy,
  div_iter_param_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_reg, state_next;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             early_reg;
  logic             accept;

  logic [FIX_N-1:0] fix_neg;
  logic [WIDTH-1:0] fix_in  [FIX_N];
  logic [WIDTH-1:0] fix_out [FIX_N];

  logic             neg_x, neg_y, y_zero, x_lt_y;
  logic [WIDTH:0]   trial, diff;

  assign neg_x  = bus.in_signed & bus.in_x[WIDTH-1];
  assign neg_y  = bus.in_signed & bus.in_y[WIDTH-1];
  assign y_zero = (bus.in_y == '0);

  assign fix_neg[FIX_ABS_X] = neg_x;
  assign fix_in[FIX_ABS_X]  = bus.in_x;
  assign fix_neg[FIX_ABS_Y] = neg_y;
  assign fix_in[FIX_ABS_Y]  = bus.in_y;
  assign fix_neg[FIX_Q]     = sign_q_reg;
  assign fix_in[FIX_Q]      = quo_reg;
  assign fix_neg[FIX_R]     = sign_r_reg;
  assign fix_in[FIX_R]      = rem_reg;

  for (genvar gi = 0; gi < FIX_N; gi++) begin : g_fix
    div_sign_fix #(.WIDTH(WIDTH)) u_fix (
      .neg (fix_neg[gi]),
      .a   (fix_in[gi]),
      .y   (fix_out[gi])
    );
  end

  assign x_lt_y = (EARLY_OUT != 0) && (fix_out[FIX_ABS_X] < fix_out[FIX_ABS_Y]);

  // Borrow out of the (WIDTH+1)-bit trial subtract is the inverted quotient bit.
  assign trial = {rem_reg, quo_reg[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_reg};

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: if (bus.in_valid && !flush) begin
        state_next = ST_CALC;
        accept     = 1'b1;
      end
      ST_CALC: if (early_reg || count_reg == LAST_CNT) state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg  <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      tag_reg    <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      early_reg  <= 1'b0;
    end else if (accept) begin
      count_reg <= '0;
      tag_reg   <= bus.in_tag;
      dvs_reg   <= fix_out[FIX_ABS_Y];
      if (y_zero) begin
        // Raw result, no sign fixup: q all ones, r = dividend as given.
        quo_reg    <= '1;
        rem_reg    <= bus.in_x;
        sign_q_reg <= 1'b0;
        sign_r_reg <= 1'b0;
        early_reg  <= 1'b1;
      end else if (x_lt_y) begin
        quo_reg    <= '0;
        rem_reg    <= fix_out[FIX_ABS_X];
        sign_q_reg <= neg_x ^ neg_y;
        sign_r_reg <= neg_x;
        early_reg  <= 1'b1;
      end else begin
        quo_reg    <= fix_out[FIX_ABS_X];
        rem_reg    <= '0;
        sign_q_reg <= neg_x ^ neg_y;
        sign_r_reg <= neg_x;
        early_reg  <= 1'b0;
      end
    end else if (state_reg == ST_CALC && !early_reg) begin
      quo_reg   <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
      rem_reg   <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.out_q     = fix_out[FIX_Q];
  assign bus.out_r     = fix_out[FIX_R];
  assign bus.out_tag   = tag_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule
